// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter for the common data bus: NUM_UNITS functional units, each with a
// one-entry holding slot, broadcast one result per cycle onto registered CDB outputs.
module cdb_rr_arbiter #(
    parameter int unsigned WIDTH     = 31,
    parameter int unsigned ROB       = 2,
    parameter int unsigned CONTROL   = 5,
    parameter int unsigned NUM_UNITS = 4,
    localparam int unsigned PTRW     = (NUM_UNITS <= 2) ? 1 : $clog2(NUM_UNITS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_UNITS-1:0]             req_valid,
    output logic [NUM_UNITS-1:0]             req_ready,
    input  logic [NUM_UNITS*(WIDTH+1)-1:0]   req_result,
    input  logic [NUM_UNITS*(ROB+1)-1:0]     req_rob,
    input  logic [NUM_UNITS-1:0]             req_is_control,
    input  logic [NUM_UNITS*(WIDTH+1)-1:0]   req_target,
    input  logic [NUM_UNITS*(CONTROL+1)-1:0] req_pc_control,
    output logic                             cdb_valid,
    output logic [WIDTH:0]                   cdb_result,
    output logic [ROB:0]                     cdb_rob,
    output logic                             cdb_is_control,
    output logic [WIDTH:0]                   cdb_target,
    output logic [CONTROL:0]                 cdb_pc_control,
    output logic [PTRW-1:0]                  cdb_unit
);

    localparam int unsigned DW = WIDTH + 1;
    localparam int unsigned RW = ROB + 1;
    localparam int unsigned CW = CONTROL + 1;

    logic [NUM_UNITS-1:0] held;
    logic [PTRW-1:0]      ptr;

    logic [DW-1:0] slot_result [NUM_UNITS];
    logic [RW-1:0] slot_rob    [NUM_UNITS];
    logic          slot_ctl    [NUM_UNITS];
    logic [DW-1:0] slot_target [NUM_UNITS];
    logic [CW-1:0] slot_pcc    [NUM_UNITS];

    logic [NUM_UNITS-1:0] acc;
    logic [NUM_UNITS-1:0] cand;
    logic                 found;
    logic [PTRW-1:0]      win;
    logic [PTRW:0]        idx;
    logic [PTRW-1:0]      ptr_nxt;

    logic [DW-1:0] w_result;
    logic [RW-1:0] w_rob;
    logic          w_ctl;
    logic [DW-1:0] w_target;
    logic [CW-1:0] w_pcc;

    assign req_ready = ~held;
    assign acc       = req_valid & ~held;
    assign cand      = held | acc;

    // Rotating first-set search starting at ptr; the found flag keeps the winner one-hot.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = {1'b0, ptr} + (PTRW+1)'(i);
            if (idx >= (PTRW+1)'(NUM_UNITS)) begin
                idx = idx - (PTRW+1)'(NUM_UNITS);
            end
            if (!found && cand[idx[PTRW-1:0]]) begin
                found = 1'b1;
                win   = idx[PTRW-1:0];
            end
        end
    end

    assign ptr_nxt = (win == PTRW'(NUM_UNITS - 1)) ? '0 : win + PTRW'(1);

    // Winner payload: the holding slot if occupied, otherwise bypass straight from the unit.
    always_comb begin
        w_result = req_result[32'(win) * DW +: DW];
        w_rob    = req_rob[32'(win) * RW +: RW];
        w_ctl    = req_is_control[win];
        w_target = req_target[32'(win) * DW +: DW];
        w_pcc    = req_pc_control[32'(win) * CW +: CW];
        if (held[win]) begin
            w_result = slot_result[win];
            w_rob    = slot_rob[win];
            w_ctl    = slot_ctl[win];
            w_target = slot_target[win];
            w_pcc    = slot_pcc[win];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held           <= '0;
            ptr            <= '0;
            cdb_valid      <= 1'b0;
            cdb_result     <= '0;
            cdb_rob        <= '0;
            cdb_is_control <= 1'b0;
            cdb_target     <= '0;
            cdb_pc_control <= '0;
            cdb_unit       <= '0;
        end else if (flush) begin
            held      <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= found;
            if (found) begin
                cdb_result     <= w_result;
                cdb_rob        <= w_rob;
                cdb_is_control <= w_ctl;
                cdb_pc_control <= w_pcc;
                cdb_unit       <= win;
                ptr            <= ptr_nxt;
                if (w_ctl) begin
                    cdb_target <= w_target;
                end
            end
            for (int j = 0; j < NUM_UNITS; j++) begin
                if (found && (win == PTRW'(j))) begin
                    held[j] <= 1'b0;
                end else if (acc[j]) begin
                    held[j] <= 1'b1;
                end
            end
        end
    end

    // Slot data needs no reset; occupancy is tracked solely by held.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_UNITS; j++) begin
            if (acc[j] && !flush) begin
                slot_result[j] <= req_result[j*DW +: DW];
                slot_rob[j]    <= req_rob[j*RW +: RW];
                slot_ctl[j]    <= req_is_control[j];
                slot_target[j] <= req_target[j*DW +: DW];
                slot_pcc[j]    <= req_pc_control[j*CW +: CW];
            end
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter (4 units, 32-bit data, 3-bit ROB tags).
module tb_cdb_rr_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_result = '0;
    logic [11:0]  req_rob = '0;
    logic [3:0]   req_is_control = '0;
    logic [127:0] req_target = '0;
    logic [23:0]  req_pc_control = '0;
    logic         cdb_valid;
    logic [31:0]  cdb_result;
    logic [2:0]   cdb_rob;
    logic         cdb_is_control;
    logic [31:0]  cdb_target;
    logic [5:0]   cdb_pc_control;
    logic [1:0]   cdb_unit;

    int n_cmp = 0;
    int n_err = 0;

    cdb_rr_arbiter dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_result(req_result), .req_rob(req_rob),
        .req_is_control(req_is_control), .req_target(req_target),
        .req_pc_control(req_pc_control),
        .cdb_valid(cdb_valid), .cdb_result(cdb_result), .cdb_rob(cdb_rob),
        .cdb_is_control(cdb_is_control), .cdb_target(cdb_target),
        .cdb_pc_control(cdb_pc_control), .cdb_unit(cdb_unit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bc(input string tag, input logic [1:0] unit, input logic [31:0] res);
        chk({tag, ".valid"}, 64'(cdb_valid), 64'd1);
        chk({tag, ".unit"}, 64'(cdb_unit), 64'(unit));
        chk({tag, ".result"}, 64'(cdb_result), 64'(res));
    endtask

    task automatic drive(input int u, input logic [31:0] res, input logic [2:0] rob,
                         input logic ctl, input logic [31:0] tgt);
        req_result[u*32 +: 32]   = res;
        req_rob[u*3 +: 3]        = rob;
        req_is_control[u]        = ctl;
        req_target[u*32 +: 32]   = tgt;
        req_pc_control[u*6 +: 6] = 6'(u + 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rdy;
        int n0, n3;
        // Reset state
        step();
        chk("rst.valid", 64'(cdb_valid), 64'd0);
        chk("rst.ready", 64'(req_ready), 64'hf);
        chk("rst.unit", 64'(cdb_unit), 64'd0);
        chk("rst.result", 64'(cdb_result), 64'd0);
        reset = 1'b0;
        step();

        // Single request from unit 2 -> ptr=3
        drive(2, 32'hDEAD_0001, 3'd5, 1'b0, 32'h0);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        chk_bc("single", 2'd2, 32'hDEAD_0001);
        chk("single.rob", 64'(cdb_rob), 64'd5);
        chk("single.pcc", 64'(cdb_pc_control), 64'd3);
        chk("single.ready", 64'(req_ready), 64'hf);
        step();
        chk("idle.valid", 64'(cdb_valid), 64'd0);
        chk("idle.hold_result", 64'(cdb_result), 64'hDEAD_0001);
        chk("idle.hold_unit", 64'(cdb_unit), 64'd2);

        // Unit 3 alone: wraps ptr back to 0
        drive(3, 32'h3333_0003, 3'd3, 1'b0, 32'h0);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        chk_bc("wrap", 2'd3, 32'h3333_0003);

        // All-units contention from ptr=0
        for (int u = 0; u < 4; u++) drive(u, 32'hA000_0000 | 32'(u), 3'(u), 1'b0, 32'h0);
        req_valid = 4'b1111;
        step();
        req_valid = '0;
        chk_bc("all0", 2'd0, 32'hA000_0000);
        chk("all0.ready", 64'(req_ready), 64'h1);
        step();
        chk_bc("all1", 2'd1, 32'hA000_0001);
        chk("all1.ready", 64'(req_ready), 64'h3);
        step();
        chk_bc("all2", 2'd2, 32'hA000_0002);
        step();
        chk_bc("all3", 2'd3, 32'hA000_0003);
        chk("all3.rob", 64'(cdb_rob), 64'd3);
        chk("all3.ready", 64'(req_ready), 64'hf);
        step();
        chk("all.idle", 64'(cdb_valid), 64'd0);

        // Units 0 and 3 at ptr=0: unit 0 first confirms ptr ended at 0
        drive(0, 32'hC000_0000, 3'd0, 1'b0, 32'h0);
        drive(3, 32'hC000_0003, 3'd3, 1'b0, 32'h0);
        req_valid = 4'b1001;
        step();
        req_valid = '0;
        chk_bc("p0a", 2'd0, 32'hC000_0000);
        chk("p0a.ready", 64'(req_ready), 64'h7);
        step();
        chk_bc("p0b", 2'd3, 32'hC000_0003);

        // Control broadcast then non-control: target sticks at 0x400
        drive(1, 32'hD000_0001, 3'd1, 1'b1, 32'h0000_0400);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk_bc("ctl1", 2'd1, 32'hD000_0001);
        chk("ctl1.is_ctl", 64'(cdb_is_control), 64'd1);
        chk("ctl1.target", 64'(cdb_target), 64'h400);
        drive(0, 32'hD000_0000, 3'd0, 1'b0, 32'h0000_0999);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk_bc("ctl0", 2'd0, 32'hD000_0000);
        chk("ctl0.is_ctl", 64'(cdb_is_control), 64'd0);
        chk("ctl0.target", 64'(cdb_target), 64'h400);

        // Unit 1 alone -> ptr=2 for the rotation test
        drive(1, 32'hE000_0001, 3'd1, 1'b0, 32'h0);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk_bc("pre_rot", 2'd1, 32'hE000_0001);

        // Rotation: units 0 and 3 always valid, new data after each accept
        n0 = 0;
        n3 = 0;
        req_valid = 4'b1001;
        for (int e = 0; e < 6; e++) begin
            drive(0, 32'h0A00_0000 | 32'(n0), 3'd0, 1'b0, 32'h0);
            drive(3, 32'h3A00_0000 | 32'(n3), 3'd3, 1'b0, 32'h0);
            rdy = req_ready;
            step();
            if (rdy[0]) n0++;
            if (rdy[3]) n3++;
            if (e % 2 == 0) chk_bc("rot3", 2'd3, 32'h3A00_0000 | 32'(e / 2));
            else            chk_bc("rot0", 2'd0, 32'h0A00_0000 | 32'(e / 2));
        end
        req_valid = '0;
        step();
        chk_bc("rot_tail", 2'd3, 32'h3A00_0003);
        step();
        chk("rot.idle", 64'(cdb_valid), 64'd0);

        // Flush with units 1 and 2 held; unit 3 offered during flush must be dropped
        for (int u = 0; u < 3; u++) drive(u, 32'hF000_0000 | 32'(u), 3'(u), 1'b0, 32'h0);
        req_valid = 4'b0111;
        step();
        chk_bc("fl.pre", 2'd0, 32'hF000_0000);
        chk("fl.pre_ready", 64'(req_ready), 64'h9);
        drive(3, 32'hF000_0003, 3'd3, 1'b0, 32'h0);
        req_valid = 4'b1000;
        flush = 1'b1;
        step();
        flush = 1'b0;
        req_valid = '0;
        chk("fl.valid", 64'(cdb_valid), 64'd0);
        chk("fl.ready", 64'(req_ready), 64'hf);
        chk("fl.hold_result", 64'(cdb_result), 64'hF000_0000);
        step();
        chk("fl.after1", 64'(cdb_valid), 64'd0);
        step();
        chk("fl.after2", 64'(cdb_valid), 64'd0);

        // ptr=1 after flush; unit 3 alone returns it to 0
        drive(3, 32'h3333_0004, 3'd4, 1'b0, 32'h0);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        chk_bc("pre_rst", 2'd3, 32'h3333_0004);

        // Build held=1010 then reset asynchronously between edges
        drive(0, 32'hB000_0000, 3'd0, 1'b0, 32'h0);
        drive(1, 32'hB000_0001, 3'd1, 1'b0, 32'h0);
        drive(3, 32'hB000_0003, 3'd3, 1'b0, 32'h0);
        req_valid = 4'b1011;
        step();
        req_valid = '0;
        chk_bc("ar.pre", 2'd0, 32'hB000_0000);
        chk("ar.pre_ready", 64'(req_ready), 64'h5);
        #3;
        reset = 1'b1;
        #1;
        chk("ar.valid", 64'(cdb_valid), 64'd0);
        chk("ar.ready", 64'(req_ready), 64'hf);
        chk("ar.result", 64'(cdb_result), 64'd0);
        #1;
        reset = 1'b0;
        step();
        chk("ar.after", 64'(cdb_valid), 64'd0);
        step();
        chk("ar.after2", 64'(cdb_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- N-channel round-robin arbiter for the common data bus. It generalises the two-unit ALU/branch arbiter to NUM_UNITS functional units.
- Each unit has a one-entry holding slot with valid/ready backpressure, so a unit that loses arbitration does not lose its result.
- Registered CDB outputs feed the reservation stations, rename stage and reorder buffer. A flush input discards all pending results on branch mispredict.

Parameters:
- WIDTH, 31: MSB index of result and target address (data is WIDTH+1 bits).
- ROB, 2: MSB index of the ROB entry tag.
- CONTROL, 5: MSB index of the pcControl field.
- NUM_UNITS, 4: number of requesting functional units, >= 2. PTRW = max(1, clog2(NUM_UNITS)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discard all pending and incoming results.
- req_valid  in  NUM_UNITS  unit i presents a result.
- req_ready  out  NUM_UNITS  unit i's slot can accept; equals ~held[i] (registered, no combinational path from req_valid).
- req_result  in  NUM_UNITS*(WIDTH+1)  packed results; unit i occupies slice i.
- req_rob  in  NUM_UNITS*(ROB+1)  packed ROB tags.
- req_is_control  in  NUM_UNITS  result belongs to a control-flow instruction.
- req_target  in  NUM_UNITS*(WIDTH+1)  packed branch targets.
- req_pc_control  in  NUM_UNITS*(CONTROL+1)  packed pcControl fields.
- cdb_valid  out  1  broadcast valid.
- cdb_result  out  WIDTH+1  broadcast result.
- cdb_rob  out  ROB+1  broadcast ROB tag.
- cdb_is_control  out  1  broadcast is control flow.
- cdb_target  out  WIDTH+1  broadcast target address.
- cdb_pc_control  out  CONTROL+1  broadcast pcControl.
- cdb_unit  out  PTRW  index of the granted unit.

Behaviour:
- Reset (asynchronous): held=0, ptr=0, all cdb_* outputs=0. Reset mid-operation drops every held entry.

Handshake and candidates:
- Unit i is accepted when req_valid[i] && req_ready[i] at a rising edge.
- Candidate set each cycle: cand[i] = held[i] | (req_valid[i] & ~held[i]).
- A candidate's payload comes from slot i if held[i], otherwise from the input bus (bypass).

Arbitration (combinational):
- Search cand in order ptr, ptr+1, … NUM_UNITS-1, 0, … ptr-1. The first set bit is winner k.
- No candidate means no grant.

Clock edge, grant to k, no flush:
- cdb_valid<=1.
- cdb_result, cdb_rob, cdb_is_control, cdb_pc_control, cdb_unit <= payload k.
- cdb_target <= target k if is_control k is set, else cdb_target holds.
- Slot k: held[k]<=0, or stays 0 if bypassed.
- Every other accepted input j (j!=k) is written into slot j, held[j]<=1.
- ptr <= (k+1) mod NUM_UNITS.

Clock edge, no candidate:
- cdb_valid<=0. Data fields, cdb_unit and ptr hold.
- ptr does not reset to 0 on idle.

Flush:
- Takes priority over grant.
- Next edge: cdb_valid<=0, held all 0; input captures are ignored even if req_ready=1.
- ptr and data fields hold.

Timing and guarantees:
- Latency: an input arriving with an empty slot and winning is on the CDB one cycle later. A held entry is broadcast within NUM_UNITS cycles of capture (starvation bound).
- Throughput: at most one broadcast per cycle.
- Occupancy: each slot holds at most one entry.
- Stalled unit: a unit whose slot is held sees req_ready=0 and must keep its result.
- Same-cycle refill: if a slot is granted this edge, req_ready rises the following cycle. There is no same-cycle refill of a slot being drained.
- Single winner: winner selection is one-hot. cdb_valid never asserts for more than one unit per cycle.

Test Plan:
- Single request: after reset, req_valid=4'b0100, result=32'hDEAD_0001, rob=3'd5 at edge t. At t+1: cdb_valid=1, result=32'hDEAD_0001, rob=5, cdb_unit=2. Then ptr=3 and held=0.
- All-units contention: req_valid=4'b1111 held for one cycle with ptr=0. Broadcasts on the next 4 cycles come from units 0,1,2,3 in order. req_ready=4'b0001 after the first edge; ptr ends at 0.
- Rotation: ptr=2, units 0 and 3 request continuously (refilled when ready). Grant order is 3,0,3,0,…; neither unit waits more than 2 cycles.
- Control broadcast: unit 1 is_control=1, target=32'h0000_0400, then unit 0 non-control with target=32'h0000_0999. cdb_target=32'h400 after both broadcasts. cdb_is_control=1 then 0.
- Flush: units 1 and 2 held, flush=1 for one cycle. Next cycle cdb_valid=0, req_ready=4'b1111, and no later broadcast carries those tags.
- Asynchronous reset: reset asserted between edges while held=4'b1010. cdb_valid=0 and req_ready=4'b1111 immediately, before the next clk edge.
